qdi_1of4_tx_sched: RTL and testbench

- Clocked scheduler that shares one binary-to-e1of4 converter among N synchronous requesters.
- Arbitrates round-robin and accepts a 2-bit token from the granted requester.
- Drives the converter's RESET/req/din with correct setup and four-phase ordering, and tracks the converter's Re enable.
- Sits at the clocked-testbench/QDI boundary and converts valid/ready traffic into single-rail-driven handshakes.

---
 rtl/qdi_1of4_tx_sched.sv | 165 ++++++++++++++++
 tb/tb_qdi_1of4_tx_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdi_1of4_tx_sched.sv
// Round-robin scheduler that shares one binary-to-e1of4 QDI converter among
// N clocked valid/ready requesters. It drives the converter's reset, req and
// din with a four-phase protocol, and watches the converter's Re enable
// through a two-flop synchronizer.
module qdi_1of4_tx_sched #(
   parameter int N          = 4,
   parameter int RST_CYCLES = 4,
   parameter int TO_CYCLES  = 1024,
   parameter int CNT_W      = 16,
   localparam int GW        = (N < 2) ? 1 : $clog2(N)
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic [N-1:0]     in_valid,
   input  logic [2*N-1:0]   in_data,
   output logic [N-1:0]     in_ready,
   output logic             req,
   output logic [1:0]       din,
   output logic             conv_reset,
   input  logic             Re,
   input  logic             clear_err,
   output logic             busy,
   output logic [GW-1:0]    grant_id,
   output logic [CNT_W-1:0] tok_count,
   output logic             timeout_err
);

   localparam int TW  = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES);
   localparam int RCW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);
   localparam logic [TW-1:0]  TO_LAST  = (TO_CYCLES == 0) ? '0 : TW'(TO_CYCLES - 1);
   localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
   localparam logic           TO_EN    = (TO_CYCLES != 0);
   localparam logic [GW-1:0]  LAST_ID  = GW'(N - 1);

   typedef enum logic [2:0] {
      RST,
      IDLE,
      SETUP,
      REQ,
      RTZ,
      ERR
   } state_t;

   state_t         state;
   logic           re_meta;
   logic           re_s;
   logic [GW-1:0]  ptr;
   logic [TW-1:0]  timer;
   logic [RCW-1:0] rst_cnt;
   logic [GW-1:0]  pick;
   logic           found;
   int             idx;

   // Bring the asynchronous Re into the clock domain before any decision uses it.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         re_meta <= 1'b0;
         re_s    <= 1'b0;
      end else begin
         re_meta <= Re;
         re_s    <= re_meta;
      end
   end

   // Round-robin pick: first valid requester scanning from ptr upward, and a
   // grant offered only while idle and the converter is enabled.
   always_comb begin
      pick     = '0;
      found    = 1'b0;
      idx      = 0;
      in_ready = '0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && in_valid[idx]) begin
            found = 1'b1;
            pick  = GW'(idx);
         end
      end
      if (state == IDLE && re_s && found) begin
         in_ready[pick] = 1'b1;
      end
   end

   assign busy = (state != IDLE);

   // Main handshake sequencer; exit conditions in REQ/RTZ beat the timeout.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state       <= RST;
         req         <= 1'b0;
         din         <= 2'b00;
         conv_reset  <= 1'b1;
         ptr         <= '0;
         grant_id    <= '0;
         tok_count   <= '0;
         timeout_err <= 1'b0;
         timer       <= '0;
         rst_cnt     <= '0;
      end else begin
         case (state)
            RST: begin
               if (rst_cnt == RST_LAST) begin
                  conv_reset <= 1'b0;
                  state      <= IDLE;
               end else begin
                  rst_cnt <= rst_cnt + RCW'(1);
               end
            end
            IDLE: begin
               if (|in_ready) begin
                  din      <= in_data[2*pick +: 2];
                  grant_id <= pick;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               req   <= 1'b1;
               timer <= '0;
               state <= REQ;
            end
            REQ: begin
               if (!re_s) begin
                  req   <= 1'b0;
                  timer <= '0;
                  state <= RTZ;
               end else if (TO_EN && timer == TO_LAST) begin
                  req         <= 1'b0;
                  din         <= 2'b00;
                  conv_reset  <= 1'b1;
                  timeout_err <= 1'b1;
                  state       <= ERR;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            RTZ: begin
               if (re_s) begin
                  din       <= 2'b00;
                  tok_count <= tok_count + CNT_W'(1);
                  ptr       <= (grant_id == LAST_ID) ? '0 : grant_id + GW'(1);
                  state     <= IDLE;
               end else if (TO_EN && timer == TO_LAST) begin
                  din         <= 2'b00;
                  conv_reset  <= 1'b1;
                  timeout_err <= 1'b1;
                  state       <= ERR;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            ERR: begin
               if (clear_err) begin
                  timeout_err <= 1'b0;
                  rst_cnt     <= '0;
                  state       <= RST;
               end
            end
            default: begin
               state <= RST;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_qdi_1of4_tx_sched.sv
// Directed bench for qdi_1of4_tx_sched: reset timing, single token,
// round-robin order, skipping, timeout/recovery, Re gating, async reset.
module tb_qdi_1of4_tx_sched;

   logic        CLK;
   logic        RESETn;
   logic [3:0]  in_valid;
   logic [7:0]  in_data;
   logic [3:0]  in_ready;
   logic        req;
   logic [1:0]  din;
   logic        conv_reset;
   logic        Re;
   logic        clear_err;
   logic        busy;
   logic [1:0]  grant_id;
   logic [15:0] tok_count;
   logic        timeout_err;

   int compared   = 0;
   int mismatched = 0;

   qdi_1of4_tx_sched #(
      .N(4), .RST_CYCLES(4), .TO_CYCLES(8), .CNT_W(16)
   ) dut (
      .CLK(CLK), .RESETn(RESETn), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .req(req), .din(din), .conv_reset(conv_reset),
      .Re(Re), .clear_err(clear_err), .busy(busy), .grant_id(grant_id),
      .tok_count(tok_count), .timeout_err(timeout_err)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Absolute guard so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed still running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] v, input logic [7:0] d);
      in_valid = v;
      in_data  = d;
   endtask

   task automatic doReset();
      int n;
      RESETn    = 1'b0;
      Re        = 1'b1;
      clear_err = 1'b0;
      applyStimulus(4'b0000, 8'h00);
      repeat (3) tick();
      RESETn = 1'b1;
      n = 0;
      while (conv_reset && n < 50) begin tick(); n++; end
      if (n >= 50) checkOutput("rst_wait", 32'd0, 32'd1);
   endtask

   // Wait for a grant, then play the converter: ack 3 cycles after req, release after req drops.
   task automatic runToken(output logic [3:0] gnt, output logic [1:0] dv, output logic [1:0] gid);
      int n;
      #1;
      n = 0;
      while (in_ready == 4'b0000 && n < 50) begin tick(); n++; end
      if (n >= 50) checkOutput("grant_wait", 32'd0, 32'd1);
      gnt = in_ready;
      tick();
      dv = din;
      tick();
      repeat (3) tick();
      Re = 1'b0;
      n = 0;
      while (req && n < 50) begin tick(); n++; end
      if (n >= 50) checkOutput("req_fall_wait", 32'd0, 32'd1);
      Re = 1'b1;
      n = 0;
      while (busy && n < 50) begin tick(); n++; end
      if (n >= 50) checkOutput("idle_wait", 32'd0, 32'd1);
      gid = grant_id;
   endtask

   logic [3:0] gnt;
   logic [1:0] dv;
   logic [1:0] gid;
   int n;
   logic [3:0] rr_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [1:0] rr_din [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   logic [3:0] sk_gnt [3] = '{4'b1000, 4'b0010, 4'b1000};

   initial begin
      RESETn    = 1'b0;
      Re        = 1'b1;
      clear_err = 1'b0;
      applyStimulus(4'b0000, 8'h00);

      // Reset state
      tick();
      checkOutput("rst_conv_reset", conv_reset, 1);
      checkOutput("rst_req", req, 0);
      checkOutput("rst_din", din, 0);
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_grant_id", grant_id, 0);
      checkOutput("rst_tok_count", tok_count, 0);
      checkOutput("rst_timeout_err", timeout_err, 0);
      checkOutput("rst_busy", busy, 1);
      repeat (2) tick();
      RESETn = 1'b1;
      #1;
      n = 0;
      while (conv_reset && n < 20) begin n++; tick(); end
      checkOutput("rst_conv_reset_cycles", n, 4);
      checkOutput("rst_idle_busy", busy, 0);

      // Single token from requester 0
      applyStimulus(4'b0001, 8'h02);
      #1;
      checkOutput("t1_in_ready", in_ready, 4'b0001);
      tick();
      applyStimulus(4'b0000, 8'h00);
      checkOutput("t1_ready_one_cycle", in_ready, 0);
      checkOutput("t1_din_setup", din, 2'b10);
      checkOutput("t1_req_before", req, 0);
      tick();
      checkOutput("t1_req_high", req, 1);
      checkOutput("t1_din_req", din, 2'b10);
      repeat (3) tick();
      Re = 1'b0;
      n = 0;
      while (req && n < 20) begin tick(); n++; end
      checkOutput("t1_req_drop_lag", n, 3);
      checkOutput("t1_din_rtz", din, 2'b10);
      Re = 1'b1;
      n = 0;
      while (busy && n < 20) begin tick(); n++; end
      checkOutput("t1_rtz_lag", n, 3);
      checkOutput("t1_tok_count", tok_count, 1);
      checkOutput("t1_grant_id", grant_id, 0);
      checkOutput("t1_din_zero", din, 0);

      // clear_err outside ERR does nothing
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      checkOutput("clr_idle_busy", busy, 0);
      checkOutput("clr_idle_conv_reset", conv_reset, 0);

      // Round-robin with all four requesters valid, data i = i
      doReset();
      applyStimulus(4'b1111, 8'hE4);
      for (int i = 0; i < 5; i++) begin
         runToken(gnt, dv, gid);
         checkOutput($sformatf("rr_grant_%0d", i), gnt, rr_gnt[i]);
         checkOutput($sformatf("rr_din_%0d", i), dv, rr_din[i]);
         checkOutput($sformatf("rr_gid_%0d", i), gid, rr_din[i]);
      end
      checkOutput("rr_tok_count", tok_count, 5);

      // Skip: move ptr to 2, then only 1 and 3 valid
      applyStimulus(4'b0010, 8'hE4);
      runToken(gnt, dv, gid);
      checkOutput("sk_pre_grant", gnt, 4'b0010);
      applyStimulus(4'b1010, 8'hE4);
      for (int i = 0; i < 3; i++) begin
         runToken(gnt, dv, gid);
         checkOutput($sformatf("sk_grant_%0d", i), gnt, sk_gnt[i]);
      end
      checkOutput("sk_tok_count", tok_count, 9);

      // Timeout in REQ with Re stuck high; ptr is 0 here
      applyStimulus(4'b0100, 8'hE4);
      #1;
      n = 0;
      while (in_ready == 4'b0000 && n < 20) begin tick(); n++; end
      checkOutput("to_grant", in_ready, 4'b0100);
      tick();
      tick();
      n = 0;
      while (req && n < 30) begin n++; tick(); end
      checkOutput("to_req_cycles", n, 8);
      checkOutput("to_timeout_err", timeout_err, 1);
      checkOutput("to_conv_reset", conv_reset, 1);
      checkOutput("to_in_ready", in_ready, 0);
      checkOutput("to_din", din, 0);
      checkOutput("to_tok_count", tok_count, 9);
      checkOutput("to_grant_id", grant_id, 2);
      applyStimulus(4'b0000, 8'h00);
      tick();
      checkOutput("to_err_holds", timeout_err, 1);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      checkOutput("to_clr_err_low", timeout_err, 0);
      n = 0;
      while (conv_reset && n < 20) begin n++; tick(); end
      checkOutput("to_rst_cycles", n, 4);
      checkOutput("to_idle", busy, 0);
      checkOutput("to_tok_after", tok_count, 9);

      // Re low at grant time; ptr kept at 0 so requester 2 wins over 3
      Re = 1'b0;
      repeat (3) tick();
      applyStimulus(4'b1100, 8'hE4);
      #1;
      checkOutput("re_low_ready0", in_ready, 0);
      tick();
      checkOutput("re_low_ready1", in_ready, 0);
      Re = 1'b1;
      n = 0;
      while (in_ready == 4'b0000 && n < 20) begin tick(); n++; end
      checkOutput("re_rise_lag", n, 2);
      checkOutput("re_grant", in_ready, 4'b0100);
      runToken(gnt, dv, gid);
      checkOutput("re_gid", gid, 2);
      checkOutput("re_din", dv, 2'd2);
      checkOutput("re_tok", tok_count, 10);

      // Reset asserted mid-REQ: req must drop without a clock edge
      applyStimulus(4'b0001, 8'hE4);
      #1;
      n = 0;
      while (in_ready == 4'b0000 && n < 20) begin tick(); n++; end
      tick();
      tick();
      checkOutput("mr_req_high", req, 1);
      #2;
      RESETn = 1'b0;
      #1;
      checkOutput("mr_req_async", req, 0);
      checkOutput("mr_conv_reset", conv_reset, 1);
      checkOutput("mr_tok_count", tok_count, 0);

      // Reset asserted mid-RTZ after one completed token
      doReset();
      applyStimulus(4'b0001, 8'hE4);
      runToken(gnt, dv, gid);
      checkOutput("rz_tok_before", tok_count, 1);
      #1;
      n = 0;
      while (in_ready == 4'b0000 && n < 20) begin tick(); n++; end
      tick();
      tick();
      Re = 1'b0;
      n = 0;
      while (req && n < 20) begin tick(); n++; end
      checkOutput("rz_in_rtz_busy", busy, 1);
      #2;
      RESETn = 1'b0;
      #1;
      checkOutput("rz_req", req, 0);
      checkOutput("rz_conv_reset", conv_reset, 1);
      checkOutput("rz_tok_count", tok_count, 0);
      checkOutput("rz_in_ready", in_ready, 0);
      checkOutput("rz_din", din, 0);
      tick();
      RESETn = 1'b1;
      Re     = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
